// File: rtl/sysa_result_drain_pkg.sv
// Shared types and constants for the systolic-array result drain.
// Register window, state encoding and buffer indexing helpers.
package edu_tpu_pkg;

  localparam int N     = 3;
  localparam int OUT_W = 16;
  localparam int NRES  = N * N;

  localparam logic [31:0] BASE_ADDRESS = 32'h3000_0100;
  localparam logic [31:0] WIN_BYTES    = 32'h20;
  localparam logic [2:0]  OFF_STATUS   = 3'd0;
  localparam logic [2:0]  OFF_RES0     = 3'd1;
  localparam logic [2:0]  OFF_RESN     = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    READY
  } drain_state_e;

  typedef logic [OUT_W-1:0] res_t;

  function automatic logic in_window(logic [31:0] a);
    return (a >= BASE_ADDRESS) && ((a - BASE_ADDRESS) < WIN_BYTES);
  endfunction

  // lane k is live for three consecutive counts starting at k
  function automatic logic lane_hit(int k, logic [2:0] cnt);
    return (int'(cnt) >= k) && (int'(cnt) <= k + 2);
  endfunction

  function automatic logic [3:0] res_idx(int k, logic [2:0] cnt);
    return 4'(N * k) + 4'(cnt) - 4'(k);
  endfunction

endpackage

// File: rtl/sysa_result_drain_if.sv
// Wishbone slave bundle for the result drain.
// Signal names keep the Caravel wrapper's view (_i into the block).
interface sysa_result_drain_if;

  logic        caravel_wb_stb_i;
  logic        caravel_wb_cyc_i;
  logic        caravel_wb_we_i;
  logic [3:0]  caravel_wb_sel_i;
  logic [31:0] caravel_wb_adr_i;
  logic [31:0] caravel_wb_dat_i;
  logic        caravel_wb_ack_o;
  logic [31:0] caravel_wb_dat_o;

  modport master (
    output caravel_wb_stb_i,
    output caravel_wb_cyc_i,
    output caravel_wb_we_i,
    output caravel_wb_sel_i,
    output caravel_wb_adr_i,
    output caravel_wb_dat_i,
    input  caravel_wb_ack_o,
    input  caravel_wb_dat_o
  );

  modport slave (
    input  caravel_wb_stb_i,
    input  caravel_wb_cyc_i,
    input  caravel_wb_we_i,
    input  caravel_wb_sel_i,
    input  caravel_wb_adr_i,
    input  caravel_wb_dat_i,
    output caravel_wb_ack_o,
    output caravel_wb_dat_o
  );

endinterface

// File: rtl/sysa_result_drain_wb_if.sv
// Wishbone decode, single-cycle registered ack and read mux.
// Control writes are reported as one-cycle strobes on the ack edge.
module drain_wb_if
  import edu_tpu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  sysa_result_drain_if.slave wb,
  input  drain_state_e state_i,
  input  res_t         res_i [NRES],
  output logic         clr_state_o,
  output logic         clr_buf_o,
  output logic         status_acc_o
);

  logic        ack_q;
  logic [31:0] dat_q;
  logic        hit;
  logic [2:0]  off;
  logic [2:0]  w;
  logic [2:0]  st;
  logic [31:0] rdata;
  res_t        pad [NRES+1];
  logic        unused_bits;

  assign off = wb.caravel_wb_adr_i[4:2];
  assign w   = off - OFF_RES0;
  assign hit = wb.caravel_wb_stb_i & wb.caravel_wb_cyc_i
             & in_window(wb.caravel_wb_adr_i) & ~ack_q;

  assign st = (state_i == READY)   ? 3'b010 :
              (state_i == CAPTURE) ? 3'b001 : 3'b000;

  // odd tail entry reads as zero
  always_comb begin
    for (int i = 0; i < NRES; i++) pad[i] = res_i[i];
    pad[NRES] = '0;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      off == OFF_STATUS:
        rdata = {29'b0, st};
      off >= OFF_RES0 && off <= OFF_RESN:
        rdata = {pad[{w, 1'b1}], pad[{w, 1'b0}]};
      default:
        rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= hit;
      if (hit) dat_q <= rdata;
    end
  end

  assign wb.caravel_wb_ack_o = ack_q;
  assign wb.caravel_wb_dat_o = dat_q;

  assign status_acc_o = hit & (off == OFF_STATUS);
  assign clr_state_o  = status_acc_o & wb.caravel_wb_we_i
                      & wb.caravel_wb_dat_i[0];
  assign clr_buf_o    = status_acc_o & wb.caravel_wb_we_i
                      & wb.caravel_wb_dat_i[1];

  assign unused_bits = ^{wb.caravel_wb_sel_i,
                         wb.caravel_wb_dat_i[31:2]};

endmodule

// File: rtl/sysa_result_drain.sv
// De-skews the 3x3 array column outputs into a 9-entry buffer.
// Optional completion interrupt: DRAIN_IRQ_EN.
module sysa_result_drain
  import edu_tpu_pkg::*;
(
  input  logic             caravel_wb_clk_i,
  input  logic             caravel_wb_rst_i,
  input  logic             start_i,
  input  logic [OUT_W-1:0] sa_out1_i,
  input  logic [OUT_W-1:0] sa_out2_i,
  input  logic [OUT_W-1:0] sa_out3_i,
  sysa_result_drain_if.slave wb,
  output logic             busy_o,
  output logic             done_o
`ifdef DRAIN_IRQ_EN
  ,
  output logic             irq_o
`endif
);

  drain_state_e state_q;
  logic [2:0]   cnt_q;
  logic         busy_q;
  logic         done_q;
  res_t         res_q [NRES];
  res_t         lane [N];
  logic         clr_state;
  logic         clr_buf;
  logic         status_acc;
  logic         to_ready;

  assign lane[0] = sa_out1_i;
  assign lane[1] = sa_out2_i;
  assign lane[2] = sa_out3_i;

  assign to_ready = (state_q == CAPTURE) && (cnt_q == 3'd4)
                  && ~clr_state;

  drain_wb_if u_wb (
    .clk_i        (caravel_wb_clk_i),
    .rst_i        (caravel_wb_rst_i),
    .wb           (wb),
    .state_i      (state_q),
    .res_i        (res_q),
    .clr_state_o  (clr_state),
    .clr_buf_o    (clr_buf),
    .status_acc_o (status_acc)
  );

  // buffer clear first so a same-edge capture write overrides it
  always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
    if (caravel_wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NRES; i++) res_q[i] <= '0;
    end else begin
      if (clr_buf) begin
        for (int i = 0; i < NRES; i++) res_q[i] <= '0;
      end
      if (start_i && state_q != CAPTURE) begin
        state_q <= CAPTURE;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (clr_state) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (state_q == CAPTURE) begin
        for (int k = 0; k < N; k++) begin
          if (lane_hit(k, cnt_q))
            res_q[res_idx(k, cnt_q)] <= lane[k];
        end
        cnt_q <= cnt_q + 3'd1;
        if (to_ready) begin
          state_q <= READY;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef DRAIN_IRQ_EN
  logic irq_q;

  always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
    if (caravel_wb_rst_i) irq_q <= 1'b0;
    else if (to_ready)    irq_q <= 1'b1;
    else if (status_acc)  irq_q <= 1'b0;
  end

  assign irq_o = irq_q;
`else
  logic unused_status;
  assign unused_status = status_acc;
`endif

endmodule

// File: tb/tb_sysa_result_drain.sv
// Bench for sysa_result_drain: random result matrices vs a
// matrix-level model of the de-skewed buffer.
module tb_sysa_result_drain;
  import edu_tpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] o1 = '0, o2 = '0, o3 = '0;
  logic        busy, done;
`ifdef DRAIN_IRQ_EN
  logic        irq;
`endif

  sysa_result_drain_if wbif ();

  sysa_result_drain dut (
    .caravel_wb_clk_i (clk),
    .caravel_wb_rst_i (rst),
    .start_i          (start),
    .sa_out1_i        (o1),
    .sa_out2_i        (o2),
    .sa_out3_i        (o3),
    .wb               (wbif),
    .busy_o           (busy),
    .done_o           (done)
`ifdef DRAIN_IRQ_EN
    ,
    .irq_o            (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] mat [3][3];
  logic [15:0] exp_res [9];
  int          lat;
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w,
                         input logic [31:0] d, output int l,
                         output logic [31:0] r);
    wbif.caravel_wb_stb_i = 1'b1;
    wbif.caravel_wb_cyc_i = 1'b1;
    wbif.caravel_wb_we_i  = w;
    wbif.caravel_wb_adr_i = a;
    wbif.caravel_wb_dat_i = d;
    l = 0;
    r = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (wbif.caravel_wb_ack_o === 1'b1) begin
        l = i;
        r = wbif.caravel_wb_dat_o;
        break;
      end
    end
    wbif.caravel_wb_stb_i = 1'b0;
    wbif.caravel_wb_cyc_i = 1'b0;
    wbif.caravel_wb_we_i  = 1'b0;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    int l;
    logic [31:0] r;
    wb_xfer(a, 1'b0, '0, l, r);
    chk({tag, "_lat"}, 32'(l), 32'd1);
    chk(tag, r, exp);
  endtask

  task automatic check_words(input string tag);
    logic [15:0] hi;
    for (int w = 0; w < 5; w++) begin
      hi = (2 * w + 1 < 9) ? exp_res[2 * w + 1] : 16'h0;
      rd_chk($sformatf("%s_w%0d", tag, w),
             BASE_ADDRESS + 32'(4 + 4 * w),
             {hi, exp_res[2 * w]});
    end
  endtask

  function automatic logic [15:0] lane_val(int k, int t);
    int j;
    j = t - 1 - k;
    if (j >= 0 && j <= 2) return mat[k][j];
    return 16'($urandom);
  endfunction

  task automatic randomize_mat();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        mat[k][j] = 16'($urandom);
  endtask

  // Model: column k row j arrives at edge 1+k+j after start;
  // a buffer-clear at edge e wipes everything written before e.
  task automatic do_capture(input string tag, input bit clr_start,
                            input int bclr);
    start = 1'b1;
    if (clr_start) begin
      wbif.caravel_wb_stb_i = 1'b1;
      wbif.caravel_wb_cyc_i = 1'b1;
      wbif.caravel_wb_we_i  = 1'b1;
      wbif.caravel_wb_adr_i = BASE_ADDRESS;
      wbif.caravel_wb_dat_i = 32'h1;
    end
    tick();
    start = 1'b0;
    wbif.caravel_wb_stb_i = 1'b0;
    wbif.caravel_wb_cyc_i = 1'b0;
    wbif.caravel_wb_we_i  = 1'b0;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_done0"}, 32'(done), 32'd0);
    for (int t = 1; t <= 5; t++) begin
      o1 = lane_val(0, t);
      o2 = lane_val(1, t);
      o3 = lane_val(2, t);
      if (t == bclr) begin
        wbif.caravel_wb_stb_i = 1'b1;
        wbif.caravel_wb_cyc_i = 1'b1;
        wbif.caravel_wb_we_i  = 1'b1;
        wbif.caravel_wb_adr_i = BASE_ADDRESS;
        wbif.caravel_wb_dat_i = 32'h2;
      end
      tick();
      if (t == bclr) begin
        chk({tag, "_bclr_ack"}, 32'(wbif.caravel_wb_ack_o), 32'd1);
        wbif.caravel_wb_stb_i = 1'b0;
        wbif.caravel_wb_cyc_i = 1'b0;
        wbif.caravel_wb_we_i  = 1'b0;
      end
      if (t == 4) chk({tag, "_done4"}, 32'(done), 32'd0);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        exp_res[3 * k + j] = (bclr > 0 && 1 + k + j < bclr)
                           ? 16'h0 : mat[k][j];
  endtask

  initial begin
    wbif.caravel_wb_stb_i = 1'b0;
    wbif.caravel_wb_cyc_i = 1'b0;
    wbif.caravel_wb_we_i  = 1'b0;
    wbif.caravel_wb_sel_i = 4'hF;
    wbif.caravel_wb_adr_i = '0;
    wbif.caravel_wb_dat_i = '0;
    for (int i = 0; i < 9; i++) exp_res[i] = '0;

    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef DRAIN_IRQ_EN
    chk("rst_irq", 32'(irq), 32'd0);
`endif
    rd_chk("rst_status", BASE_ADDRESS, 32'h0);
    check_words("rst");

    // directed 1..9 pattern
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        mat[k][j] = 16'(3 * k + j + 1);
    do_capture("dir", 1'b0, 0);
`ifdef DRAIN_IRQ_EN
    chk("dir_irq", 32'(irq), 32'd1);
`endif
    rd_chk("dir_status", BASE_ADDRESS, 32'h2);
`ifdef DRAIN_IRQ_EN
    chk("dir_irq_clr", 32'(irq), 32'd0);
`endif
    chk("dir_done_kept", 32'(done), 32'd1);
    rd_chk("dir_w0", BASE_ADDRESS + 32'h04, 32'h0002_0001);
    rd_chk("dir_w4", BASE_ADDRESS + 32'h14, 32'h0000_0009);
    check_words("dir");

    // control clear keeps buffer, buffer clear zeroes it
    wb_xfer(BASE_ADDRESS, 1'b1, 32'h1, lat, rd);
    chk("clr_lat", 32'(lat), 32'd1);
    chk("clr_done", 32'(done), 32'd0);
    rd_chk("clr_status", BASE_ADDRESS, 32'h0);
    rd_chk("clr_keep", BASE_ADDRESS + 32'h04, 32'h0002_0001);
    wb_xfer(BASE_ADDRESS, 1'b1, 32'h2, lat, rd);
    chk("bclr_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 9; i++) exp_res[i] = '0;
    rd_chk("bclr_w0", BASE_ADDRESS + 32'h04, 32'h0);
    check_words("bclr");

    // window edges
    wb_xfer(32'h3000_0200, 1'b0, '0, lat, rd);
    chk("oow_noack", 32'(lat), 32'd0);
    wb_xfer(BASE_ADDRESS - 32'h4, 1'b0, '0, lat, rd);
    chk("below_noack", 32'(lat), 32'd0);
    rd_chk("r1c", BASE_ADDRESS + 32'h1C, 32'h0);
    wb_xfer(BASE_ADDRESS + 32'h18, 1'b1, 32'hFFFF_FFFF, lat, rd);
    chk("w18_lat", 32'(lat), 32'd1);
    rd_chk("r18", BASE_ADDRESS + 32'h18, 32'h0);
    wb_xfer(BASE_ADDRESS + 32'h08, 1'b1, 32'hDEAD_BEEF, lat, rd);
    check_words("ro");

    // random matrices, one with a mid-capture buffer clear
    for (int r = 0; r < 3; r++) begin
      randomize_mat();
      do_capture($sformatf("rnd%0d", r), 1'b0, (r == 1) ? 3 : 0);
      check_words($sformatf("rnd%0d", r));
      rd_chk($sformatf("rnd%0d_st", r), BASE_ADDRESS, 32'h2);
    end

    // start and control clear on the same edge
    randomize_mat();
    do_capture("sclr", 1'b1, 0);
    check_words("sclr");

    // reset mid-capture
    randomize_mat();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      o1 = lane_val(0, t);
      o2 = lane_val(1, t);
      o3 = lane_val(2, t);
      tick();
    end
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_ack", 32'(wbif.caravel_wb_ack_o), 32'd0);
    chk("mrst_dat", wbif.caravel_wb_dat_o, 32'h0);
`ifdef DRAIN_IRQ_EN
    chk("mrst_irq", 32'(irq), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) exp_res[i] = '0;
    rd_chk("mrst_status", BASE_ADDRESS, 32'h0);
    check_words("mrst");
    randomize_mat();
    do_capture("post", 1'b0, 0);
    check_words("post");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
